// File: rtl/vga_pixel_iterator_if.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_iterator_if
//  Purpose  : Raster position, sync and strobe bundle from the VGA iterator.
//  Revision : 1.0  initial release
// ============================================================================
interface vga_pixel_iterator_if;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       h_sync;
    logic       v_sync;
    logic       draw_active;
    logic       screen_end;
    logic       draw_end;

    modport master (
        output pix_x, pix_y, h_sync, v_sync, draw_active, screen_end, draw_end
    );

    modport slave (
        input  pix_x, pix_y, h_sync, v_sync, draw_active, screen_end, draw_end
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_iterator.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_iterator
//  Purpose  : 640x480@60 raster counter advanced by pix_clk rising edges,
//             decoding pixel coordinate, active-low syncs and frame strobes.
//  Revision : 1.0  initial release
// ============================================================================
module vga_pixel_iterator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire                   clk,
    input  wire                   rst,
    input  wire                   pix_clk,
    vga_pixel_iterator_if.master  vga
);

    localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HS_START = H_ACTIVE + H_FP;
    localparam int c_HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_VS_START = V_ACTIVE + V_FP;
    localparam int c_VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic       r_pix_clk_q;
    logic       r_run;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    int         w_h_pos;
    int         w_v_pos;
    logic       w_tick;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_draw;

    assign w_h_pos  = int'(r_h_cnt);
    assign w_v_pos  = int'(r_v_cnt);

    // r_run blocks the first cycle after reset so a pix_clk that is already
    // high at release is captured by r_pix_clk_q instead of ticking.
    assign w_tick   = r_run & pix_clk & ~r_pix_clk_q;
    assign w_h_last = (w_h_pos == c_H_TOTAL - 1);
    assign w_v_last = (w_v_pos == c_V_TOTAL - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_clk_q <= 1'b0;
            r_run       <= 1'b0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
        end else begin
            r_pix_clk_q <= pix_clk;
            r_run       <= 1'b1;
            if (w_tick) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
                end else begin
                    r_h_cnt <= r_h_cnt + 10'd1;
                end
            end
        end
    end

    assign w_draw          = rst && (w_h_pos < H_ACTIVE) && (w_v_pos < V_ACTIVE);

    assign vga.draw_active = w_draw;
    assign vga.pix_x       = w_draw ? r_h_cnt : 10'd0;
    assign vga.pix_y       = w_draw ? r_v_cnt[8:0] : 9'd0;
    assign vga.h_sync      = !((w_h_pos >= c_HS_START) && (w_h_pos < c_HS_END));
    assign vga.v_sync      = !((w_v_pos >= c_VS_START) && (w_v_pos < c_VS_END));
    assign vga.draw_end    = w_tick && (w_h_pos == H_ACTIVE - 1) && (w_v_pos == V_ACTIVE - 1);
    assign vga.screen_end  = w_tick && w_h_last && w_v_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_iterator.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pixel_iterator
//  Purpose  : Directed bench: full-size line timing on one instance, whole
//             frames on a reduced 40x20 instance, pix_clk hold, async reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pixel_iterator;

    logic clk;
    logic rst;
    logic pix_clk;
    logic pix_hold;
    logic mon_en;

    int   n_checks = 0;
    int   n_errors = 0;

    vga_pixel_iterator_if d_if ();
    vga_pixel_iterator_if s_if ();

    vga_pixel_iterator dut (
        .clk     (clk),
        .rst     (rst),
        .pix_clk (pix_clk),
        .vga     (d_if)
    );

    // Reduced raster: 20+4+8+8 = 40 columns, 10+3+2+5 = 20 lines, 800 ticks/frame
    vga_pixel_iterator #(
        .H_ACTIVE (20), .H_FP (4), .H_SYNC (8), .H_BP (8),
        .V_ACTIVE (10), .V_FP (3), .V_SYNC (2), .V_BP (5)
    ) dut_s (
        .clk     (clk),
        .rst     (rst),
        .pix_clk (pix_clk),
        .vga     (s_if)
    );

    // clk rises at 2+4k; pix_clk toggles 0.5 ns after each clk fall (period 8 ns)
    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    initial begin
        pix_clk = 1'b0;
        #0.5;
        forever begin
            if (!pix_hold) pix_clk = ~pix_clk;
            #4;
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_pix_x"},       d_if.pix_x,       0);
        chk({pfx, "_pix_y"},       d_if.pix_y,       0);
        chk({pfx, "_h_sync"},      d_if.h_sync,      1);
        chk({pfx, "_v_sync"},      d_if.v_sync,      1);
        chk({pfx, "_draw_active"}, d_if.draw_active, 0);
        chk({pfx, "_draw_end"},    d_if.draw_end,    0);
        chk({pfx, "_screen_end"},  d_if.screen_end,  0);
        chk({pfx, "_s_active"},    s_if.draw_active, 0);
    endtask

    // Monitor: samples 0.5 ns before each rising clk edge
    event smp;
    logic prev_pix = 1'b0;
    logic t_tick;
    int   tk = 0;
    int   strb_cnt = 0;
    int   d_act = 0, d_ramp_err = 0, d_hs_low = 0, d_hs_first = -1;
    int   d_vs_low = 0, d_strb = 0, d_act799 = -1, d_act800 = -1, d_x800 = -1, d_y800 = -1;
    int   s_act = 0, s_vs_low = 0, s_vs_first = -1, s_hs_low = 0, s_hs_first = -1;
    int   s_de_cnt = 0, s_se_cnt = 0, s_se_ok = 0, s_de_x = -1, s_de_y = -1;
    int   s_de_idx [2] = '{-1, -1};
    int   s_se_idx [2] = '{-1, -1};
    logic s_se_pend = 1'b0;

    always @(negedge clk) begin
        #1.5;
        t_tick   = pix_clk && !prev_pix;
        prev_pix = pix_clk;
        if (d_if.draw_end || d_if.screen_end || s_if.draw_end || s_if.screen_end) strb_cnt++;
        if (!mon_en) begin
            tk = 0;
        end else begin
            if (s_se_pend) begin
                if (s_if.draw_active && s_if.pix_x == 0 && s_if.pix_y == 0) s_se_ok++;
                s_se_pend = 1'b0;
            end
            if (s_if.draw_end) begin
                if (s_de_cnt < 2) s_de_idx[s_de_cnt] = tk;
                s_de_x = s_if.pix_x;
                s_de_y = s_if.pix_y;
                s_de_cnt++;
            end
            if (s_if.screen_end) begin
                if (s_se_cnt < 2) s_se_idx[s_se_cnt] = tk;
                s_se_cnt++;
                s_se_pend = 1'b1;
            end
            if (d_if.draw_end || d_if.screen_end) d_strb++;
            if (t_tick) begin
                if (tk < 800) begin
                    if (d_if.draw_active) begin
                        if (d_if.pix_x != d_act || d_if.pix_y != 0) d_ramp_err++;
                        d_act++;
                    end else if (d_if.pix_x != 0 || d_if.pix_y != 0) begin
                        d_ramp_err++;
                    end
                    if (!d_if.h_sync) begin
                        if (d_hs_first < 0) d_hs_first = tk;
                        d_hs_low++;
                    end
                    if (s_if.draw_active) s_act++;
                    if (!s_if.v_sync) begin
                        if (s_vs_first < 0) s_vs_first = tk;
                        s_vs_low++;
                    end
                end
                if (tk < 40 && !s_if.h_sync) begin
                    if (s_hs_first < 0) s_hs_first = tk;
                    s_hs_low++;
                end
                if (tk == 799) d_act799 = d_if.draw_active;
                if (tk == 800) begin
                    d_act800 = d_if.draw_active;
                    d_x800   = d_if.pix_x;
                    d_y800   = d_if.pix_y;
                end
                if (!d_if.v_sync) d_vs_low++;
                tk++;
            end
        end
        -> smp;
    end

    int   n;
    int   sx, sy, shs, svs, sda, ssx;

    initial begin
        rst      = 1'b0;
        pix_hold = 1'b0;
        mon_en   = 1'b0;

        // Reset held while pix_clk runs: nothing may move
        #99;
        chk_reset("rst0");
        chk("rst0_strobes", strb_cnt, 0);

        // Release with pix_clk low; the first tick comes on the next rising edge
        @(negedge pix_clk);
        #0.5;
        rst    = 1'b1;
        mon_en = 1'b1;

        n = 0;
        while (tk < 1700 && n < 4000) begin
            @(smp);
            n++;
        end
        chk("phaseA_reached", int'(tk >= 1700), 1);
        mon_en = 1'b0;

        // Full-size instance, first line
        chk("line_active_ticks",  d_act,      640);
        chk("line_pix_x_ramp",    d_ramp_err, 0);
        chk("line_hsync_ticks",   d_hs_low,   96);
        chk("line_hsync_start",   d_hs_first, 656);
        chk("line_end_inactive",  d_act799,   0);
        chk("wrap_active",        d_act800,   1);
        chk("wrap_pix_x",         d_x800,     0);
        chk("wrap_pix_y",         d_y800,     1);
        chk("full_no_vsync",      d_vs_low,   0);
        chk("full_no_strobes",    d_strb,     0);

        // Reduced instance, two whole frames
        chk("frame_active_ticks", s_act,      200);
        chk("frame_vsync_ticks",  s_vs_low,   80);
        chk("frame_vsync_start",  s_vs_first, 520);
        chk("frame_hsync_ticks",  s_hs_low,   8);
        chk("frame_hsync_start",  s_hs_first, 24);
        chk("draw_end_count",     s_de_cnt,   2);
        chk("draw_end_idx0",      s_de_idx[0], 379);
        chk("draw_end_idx1",      s_de_idx[1], 1179);
        chk("draw_end_x",         s_de_x,     19);
        chk("draw_end_y",         s_de_y,     9);
        chk("screen_end_count",   s_se_cnt,   2);
        chk("screen_end_idx0",    s_se_idx[0], 799);
        chk("screen_end_idx1",    s_se_idx[1], 1599);
        chk("screen_end_period",  s_se_idx[1] - s_se_idx[0], 800);
        chk("draw_to_screen_end", s_se_idx[0] - s_de_idx[0], 420);
        chk("screen_end_to_0_0",  s_se_ok,    2);

        // pix_clk frozen for 50 clk: raster holds, no strobes
        @(smp);
        pix_hold = 1'b1;
        repeat (3) @(smp);
        sx  = d_if.pix_x;  sy  = d_if.pix_y;  shs = d_if.h_sync;
        svs = d_if.v_sync; sda = d_if.draw_active; ssx = s_if.pix_x;
        strb_cnt = 0;
        repeat (50) @(smp);
        chk("hold_pix_x",   d_if.pix_x,       sx);
        chk("hold_pix_y",   d_if.pix_y,       sy);
        chk("hold_h_sync",  d_if.h_sync,      shs);
        chk("hold_v_sync",  d_if.v_sync,      svs);
        chk("hold_active",  d_if.draw_active, sda);
        chk("hold_s_pix_x", s_if.pix_x,       ssx);
        chk("hold_strobes", strb_cnt,         0);
        pix_hold = 1'b0;

        // Asynchronous reset mid-line, between clk edges
        n = 0;
        while (d_if.pix_x != 300 && n < 4000) begin
            @(smp);
            n++;
        end
        chk("reach_x300", d_if.pix_x, 300);
        #0.7;
        rst = 1'b0;
        #0.1;
        chk_reset("async");
        repeat (10) @(smp);
        chk_reset("held");

        // Release while pix_clk is already high: that level must not tick
        @(posedge pix_clk);
        #1.2;
        rst = 1'b1;
        @(smp);
        chk("rel_pix_x",   d_if.pix_x,       0);
        chk("rel_pix_y",   d_if.pix_y,       0);
        chk("rel_active",  d_if.draw_active, 1);
        @(smp);
        chk("rel_no_early_tick", d_if.pix_x, 0);
        @(smp);
        chk("rel_first_tick_x",  d_if.pix_x, 1);
        chk("rel_first_tick_sx", s_if.pix_x, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
